// File: rtl/modulo_n_adj_counter.sv
// -----------------------------------------------------------------------------
// modulo_n_adj_counter
//
// Modulo-MOD up/down counter for one time-of-day field (seconds, minutes or
// hours). It has a synchronous load, registered carry/borrow pulses for
// cascading into the next field, and a button-adjust FSM with
// hold-to-auto-repeat.
//
// Parameters: the count runs 0..MOD-1 in a WIDTH-bit register and resets to
// RST_VAL. A held button auto-repeats after HOLD_CYCLES, then every
// REPEAT_CYCLES.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous reset, active-high, highest priority
//   en         one-cycle count tick
//   upDown     tick direction, 1 = up, 0 = down
//   adj_up     debounced increment-adjust button level
//   adj_down   debounced decrement-adjust button level
//   load       synchronous load strobe
//   load_val   value to load; values >= MOD are clamped to MOD-1
//   count      registered current value
//   carry      one-cycle pulse after a tick wraps MOD-1 -> 0
//   borrow     one-cycle pulse after a tick wraps 0 -> MOD-1
//   adj_active high while the adjust FSM is not IDLE
//   bcd_tens   (MODN_BCD_EN only) count / 10
//   bcd_ones   (MODN_BCD_EN only) count % 10
//   dbg_state  adjust FSM state: 0 = IDLE, 1 = DELAY, 2 = REPEAT
//
// Optional feature: define MODN_BCD_EN to add the combinational BCD outputs.
// That build requires MOD <= 100.
//
// Handshake: there is no valid/ready handshake. en, load and the button
// levels are sampled on every rising clk edge, and the outputs change only on
// that edge.
//
// Update priority within one cycle: rst > load > adjust step > en tick.
// -----------------------------------------------------------------------------
module modulo_n_adj_counter #(
  parameter int WIDTH         = 5,
  parameter int MOD           = 24,
  parameter int RST_VAL       = 0,
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             upDown,
  input  logic             adj_up,
  input  logic             adj_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             adj_active,
`ifdef MODN_BCD_EN
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
`endif
  output logic [1:0]       dbg_state
);

  // The timer only needs to reach max(HOLD, REPEAT)-1. It is kept at least
  // one bit wide so that degenerate parameter sets still elaborate.
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [WIDTH-1:0] L_TOP       = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] L_RST       = WIDTH'(RST_VAL);
  localparam logic [TW-1:0]    L_HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    L_REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_dir,   w_dir_nxt;     // latched direction, 1 = up
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_borrow, w_borrow_nxt;

  logic             w_press;
  logic             w_abort;
  logic             w_step;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  // A press is exactly one button. Both buttons together count as no press.
  assign w_press = adj_up ^ adj_down;
  // Leave DELAY/REPEAT on release, on both buttons, or on a direction change.
  // A direction change costs one edge in IDLE before the new press is taken.
  assign w_abort = !w_press || (adj_up != r_dir);

  assign w_inc = (r_count == L_TOP)    ? '0    : r_count + 1'b1;
  assign w_dec = (r_count == '0)       ? L_TOP : r_count - 1'b1;

  // Adjust FSM: next state, timer and step request.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_step      = 1'b1;
          w_dir_nxt   = adj_up;
          w_state_nxt = S_DELAY;
          w_timer_nxt = '0;
        end
      end
      S_DELAY: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == L_HOLD_LAST) begin
          w_step      = 1'b1;
          w_state_nxt = S_REPEAT;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_REPEAT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == L_REP_LAST) begin
          w_step      = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Count datapath. A load overrides and discards a step due in the same
  // cycle, but it leaves the FSM alone. Ticks only act while the FSM is idle.
  always_comb begin
    w_count_nxt  = r_count;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_count_nxt = (load_val > L_TOP) ? L_TOP : load_val;
    end else if (w_step) begin
      // During a step adj_up always matches the latched direction, because a
      // mismatch aborts the FSM instead of stepping.
      w_count_nxt = adj_up ? w_inc : w_dec;
    end else if (en && (r_state == S_IDLE)) begin
      if (upDown) begin
        w_count_nxt = w_inc;
        w_carry_nxt = (r_count == L_TOP);
      end else begin
        w_count_nxt  = w_dec;
        w_borrow_nxt = (r_count == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_dir    <= 1'b0;
      r_count  <= L_RST;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_dir    <= w_dir_nxt;
      r_count  <= w_count_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign count      = r_count;
  assign carry      = r_carry;
  assign borrow     = r_borrow;
  assign adj_active = (r_state != S_IDLE);
  assign dbg_state  = r_state;

`ifdef MODN_BCD_EN
  if (MOD > 100) begin : g_bcd_range
    $error("modulo_n_adj_counter: MODN_BCD_EN requires MOD <= 100");
  end
  assign bcd_tens = 4'(int'(r_count) / 10);
  assign bcd_ones = 4'(int'(r_count) % 10);
`endif

endmodule

// File: tb/tb_modulo_n_adj_counter.sv
module tb_modulo_n_adj_counter;

  localparam int WIDTH  = 5;
  localparam int MOD    = 24;
  localparam int RSTV   = 0;
  localparam int HOLD   = 4;
  localparam int REP    = 2;
  localparam int SB_W   = WIDTH + 5;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst, en, upDown, adj_up, adj_down, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             carry, borrow, adj_active;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  modulo_n_adj_counter #(
    .WIDTH(WIDTH), .MOD(MOD), .RST_VAL(RSTV),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .upDown(upDown),
    .adj_up(adj_up), .adj_down(adj_down), .load(load), .load_val(load_val),
    .count(count), .carry(carry), .borrow(borrow), .adj_active(adj_active),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: counts how many consecutive edges the same single press
  // has been sampled and derives the step times from that count.
  int  m_count  = RSTV;
  bit  m_active = 0;
  bit  m_dir    = 0;
  int  m_held   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_push();
    bit press, stp, was_idle, cy, bw;
    logic [1:0] st;
    press = adj_up ^ adj_down;
    cy = 0; bw = 0; stp = 0;
    if (rst) begin
      m_count = RSTV; m_active = 0; m_held = 0;
    end else begin
      was_idle = !m_active;
      if (!m_active) begin
        if (press) begin
          stp = 1; m_active = 1; m_dir = adj_up; m_held = 0;
        end
      end else if (!press || (adj_up != m_dir)) begin
        m_active = 0;
      end else begin
        m_held++;
        if (m_held == HOLD || (m_held > HOLD && ((m_held - HOLD) % REP) == 0)) stp = 1;
      end
      if (load) begin
        m_count = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
      end else if (stp) begin
        m_count = adj_up ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
      end else if (en && was_idle) begin
        if (upDown) begin
          cy = (m_count == MOD - 1);
          m_count = (m_count + 1) % MOD;
        end else begin
          bw = (m_count == 0);
          m_count = (m_count + MOD - 1) % MOD;
        end
      end
    end
    st = !m_active ? 2'd0 : (m_held < HOLD ? 2'd1 : 2'd2);
    exp_q.push_back({WIDTH'(m_count), cy, bw, m_active, st});
  endtask

  // One clock: predict, advance, then compare well after the edge.
  task automatic run_cycle();
    logic [SB_W-1:0] e;
    model_push();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("sb", {count, carry, borrow, adj_active, dbg_state}, e);
    end
  endtask

  task automatic drive_idle();
    rst = 0; en = 0; upDown = 1; adj_up = 0; adj_down = 0; load = 0; load_val = '0;
  endtask

  int n_carry, n_borrow, n_act;

  initial begin
    drive_idle();
    rst = 1;
    #2;

    // ---- 1: reset then 24 up ticks ----
    run_cycle();
    check_val("rst_count", count, RSTV);
    check_val("rst_active", adj_active, 0);
    rst = 0;
    n_carry = 0; n_borrow = 0;
    for (int i = 0; i < 24; i++) begin
      en = 1; upDown = 1;
      run_cycle();
      n_carry += carry; n_borrow += borrow;
      if (i == 23) check_val("t1_carry_after_wrap", carry, 1);
    end
    en = 0;
    run_cycle();
    n_carry += carry;
    check_val("t1_count_wrap", count, 0);
    check_val("t1_carry_pulses", n_carry, 1);
    check_val("t1_borrow_none", n_borrow, 0);

    // ---- 2: down wrap ----
    en = 1; upDown = 0;
    run_cycle();
    check_val("t2_count_23", count, 23);
    check_val("t2_borrow", borrow, 1);
    run_cycle();
    check_val("t2_count_22", count, 22);
    check_val("t2_borrow_clear", borrow, 0);
    drive_idle();

    // ---- 3: hold adj_up 9 cycles from count 5, ticks ignored ----
    load = 1; load_val = 5;
    run_cycle();
    load = 0;
    n_carry = 0; n_act = 0;
    for (int i = 0; i < 9; i++) begin
      adj_up = 1; en = i[0]; upDown = 1;
      run_cycle();
      n_carry += carry; n_act += adj_active;
    end
    check_val("t3_count", count, 9);
    check_val("t3_active_cycles", n_act, 9);
    check_val("t3_no_carry", n_carry, 0);
    drive_idle();
    run_cycle();

    // ---- 4: clamp, load beats step, both-buttons no step ----
    load = 1; load_val = 30;
    run_cycle();
    check_val("t4_clamp", count, 23);
    load = 1; load_val = 7; en = 1; adj_up = 1;
    run_cycle();
    check_val("t4_load_wins", count, 7);
    drive_idle();
    run_cycle();
    adj_up = 1; adj_down = 1;
    run_cycle();
    check_val("t4_both_nostep", count, 7);
    check_val("t4_both_idle", adj_active, 0);
    drive_idle();
    run_cycle();

    // ---- 5: direction change while held ----
    adj_up = 1;
    run_cycle();
    run_cycle();
    check_val("t5_up_step", count, 8);
    adj_up = 0; adj_down = 1;
    run_cycle();
    check_val("t5_idle_at_m", dbg_state, 0);
    check_val("t5_count_at_m", count, 8);
    run_cycle();
    check_val("t5_step_m1", count, 7);
    for (int i = 0; i < 3; i++) run_cycle();
    check_val("t5_hold_m4", count, 7);
    run_cycle();
    check_val("t5_step_m5", count, 6);
    check_val("t5_repeat", dbg_state, 2);

    // ---- 6: reset in REPEAT with adj_down still held ----
    rst = 1;
    run_cycle();
    check_val("t6_rst_count", count, RSTV);
    check_val("t6_rst_active", adj_active, 0);
    rst = 0;
    run_cycle();
    check_val("t6_count_23", count, 23);
    check_val("t6_delay", dbg_state, 1);
    drive_idle();
    run_cycle();

    // ---- random traffic, buttons change rarely so repeats happen ----
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 19) == 0);
      load_val = WIDTH'($urandom_range(0, 31));
      en = $urandom_range(0, 1);
      upDown = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        adj_up = $urandom_range(0, 1);
        adj_down = $urandom_range(0, 1);
      end
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
